dm_resp: RTL

DM_RESP -- requirements
Module: dm_resp

---
 rtl/dm_resp_if.sv | 27 ++
 rtl/dm_resp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dm_resp_if.sv
// Request/response bus between the M-stage requester and the data-memory responder.
`timescale 1ns/1ps
interface dm_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        busy;

  // responder side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, busy
  );

  // requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/dm_resp.sv
// Fixed-latency data-memory responder: one request in flight, word store with
// byte lanes, load returns the full word.
//
//   state | meaning
//   IDLE  | ready for a request (once the first edge after reset has passed)
//   WAIT  | request latched, counting down the remaining latency
//   RESP  | response presented; store already committed on entry
`timescale 1ns/1ps
module dm_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic      clk,
  input logic      reset,
  dm_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_rst_done;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_pc;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_ready;
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [31:0]   w_pc;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic          w_unused_addr;

  // Address bits outside the word index are deliberately ignored.
  assign w_unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  assign w_accept     = bus.req_valid & w_ready;
  assign w_enter_resp = (r_state != RESP) && (w_next == RESP);

  // With LATENCY=1 the RESP entry coincides with acceptance, so the entry
  // datapath must see the live request rather than the latched copy.
  assign w_we    = (r_state == IDLE) ? bus.req_we : r_we;
  assign w_idx   = (r_state == IDLE) ? bus.req_addr[AW+1:2] : r_idx;
  assign w_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
  assign w_be    = (r_state == IDLE) ? bus.req_be : r_be;
  assign w_pc    = (r_state == IDLE) ? bus.req_pc : r_pc;
  assign w_old   = r_mem[w_idx];

  // Byte-lane merge of store data over the current word.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end

  // State register; r_rst_done holds req_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rst_done <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd1) w_next = RESP;
      RESP: if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    w_ready        = (r_state == IDLE) && r_rst_done;
    bus.req_ready  = w_ready;
    bus.resp_valid = (r_state == RESP);
    bus.busy       = (r_state != IDLE);
    bus.resp_rdata = r_rdata;
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_pc    <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_we    <= bus.req_we;
      r_idx   <= bus.req_addr[AW+1:2];
      r_wdata <= bus.req_wdata;
      r_be    <= bus.req_be;
      r_pc    <= bus.req_pc;
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Response data is captured only on RESP entry, so it holds under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rdata <= '0;
    else if (w_enter_resp) r_rdata <= w_we ? 32'h0 : w_old;
  end

  // Storage; a store commits once, on RESP entry, and reset clears every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (w_enter_resp && w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only store log at the commit edge.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_we)
      $display("@%h: *%h <= %h", w_pc, 32'({w_idx, 2'b00}), w_merged);
  end
`endif
endmodule
